// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared constants and types for the matrix accumulate output path.
//   DATA_WIDTH     : width of one accumulated result word
//   M_SIZE         : maximum words per row (drain buffer depth)
//   OUT_WIDTH      : width of one output byte
//   BYTES_PER_WORD : output bytes emitted per result word
//   CNT_WIDTH      : width of a counter that can hold 0..M_SIZE
//   drain_state_t  : drain FSM states (CSUM exists only when
//                    MATRIX_DRAIN_CHECKSUM_EN is defined)
// -----------------------------------------------------------------------------
package matrix_pkg;

   localparam int DATA_WIDTH     = 16;
   localparam int M_SIZE         = 4;
   localparam int OUT_WIDTH      = 8;
   localparam int BYTES_PER_WORD = DATA_WIDTH / OUT_WIDTH;
   localparam int CNT_WIDTH      = $clog2(M_SIZE + 1);

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      DRAIN = 2'd1
`ifdef MATRIX_DRAIN_CHECKSUM_EN
      ,CSUM = 2'd2
`endif
   } drain_state_t;

   // Index width that stays at least one bit wide for degenerate sizes.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/matrix_drain_buffer.sv
// -----------------------------------------------------------------------------
// matrix_drain_buffer
// Row buffer for the result drain: M_SIZE x DATA_WIDTH register array with a
// synchronous write port and a combinational read port. Contents are not reset.
//   clock   : system clock
//   wr_en   : write strobe
//   wr_idx  : write entry index
//   wr_data : word to store
//   rd_idx  : read entry index
//   rd_data : word at rd_idx (combinational)
// -----------------------------------------------------------------------------
module matrix_drain_buffer #(
   parameter int DATA_WIDTH = matrix_pkg::DATA_WIDTH,
   parameter int M_SIZE     = matrix_pkg::M_SIZE,
   parameter int IDX_WIDTH  = matrix_pkg::clog2_min1(matrix_pkg::M_SIZE)
) (
   input  logic                  clock,
   input  logic                  wr_en,
   input  logic [IDX_WIDTH-1:0]  wr_idx,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [IDX_WIDTH-1:0]  rd_idx,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [M_SIZE];

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/matrix_result_drain.sv
// -----------------------------------------------------------------------------
// matrix_result_drain
// Captures one row of accumulator results (up to M_SIZE words) and streams it
// out least-significant byte first over a valid/ready byte interface.
// Optional feature: define MATRIX_DRAIN_CHECKSUM_EN to append one XOR checksum
// byte of all data bytes after the row; out_last then marks the checksum byte.
//   clock     : system clock
//   reset     : asynchronous, active-low reset
//   in_valid  : result word present on in_data
//   in_data   : accumulated result word
//   in_last   : in_data is the final word of the row
//   in_ready  : drain can accept a word (FILL state)
//   out_valid : byte present on out_data
//   out_data  : output byte (zero when out_valid is low)
//   out_last  : final byte of the row (zero when out_valid is low)
//   out_ready : downstream accepts the byte
//   busy      : not FILL, or words already captured
// -----------------------------------------------------------------------------
module matrix_result_drain #(
   parameter int DATA_WIDTH = matrix_pkg::DATA_WIDTH,
   parameter int M_SIZE     = matrix_pkg::M_SIZE,
   parameter int OUT_WIDTH  = matrix_pkg::OUT_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic                  busy
);

   import matrix_pkg::*;

   localparam int BPW = DATA_WIDTH / OUT_WIDTH;
   localparam int CW  = $clog2(M_SIZE + 1);
   localparam int IW  = matrix_pkg::clog2_min1(M_SIZE);
   localparam int BW  = matrix_pkg::clog2_min1(BPW);

   drain_state_t          state;
   drain_state_t          next_state;
   logic                  out_valid_q;
   logic [CW-1:0]         wr_cnt;
   logic [CW-1:0]         rd_idx;
   logic [BW-1:0]         byte_sel;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [OUT_WIDTH-1:0]  cur_byte;
   logic                  accept;
   logic                  row_done;
   logic                  out_hs;
   logic                  last_byte;
   logic                  last_word;
   logic                  data_end;
`ifdef MATRIX_DRAIN_CHECKSUM_EN
   logic [OUT_WIDTH-1:0]  csum;
`endif

   // Handshake and position decode
   assign accept    = in_valid && (state == FILL);
   assign row_done  = accept && (in_last || (wr_cnt == CW'(M_SIZE - 1)));
   assign out_hs    = out_valid_q && out_ready;
   assign last_byte = (byte_sel == BW'(BPW - 1));
   assign last_word = (rd_idx == (wr_cnt - CW'(1)));
   assign data_end  = (state == DRAIN) && last_byte && last_word;

   matrix_drain_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .M_SIZE     (M_SIZE),
      .IDX_WIDTH  (IW)
   ) u_buffer (
      .clock   (clock),
      .wr_en   (accept),
      .wr_idx  (wr_cnt[IW-1:0]),
      .wr_data (in_data),
      .rd_idx  (rd_idx[IW-1:0]),
      .rd_data (rd_word)
   );

   // Byte lane select, LSB lane first
   always_comb begin
      cur_byte = '0;
      for (int unsigned b = 0; b < BPW; b++) begin
         if (byte_sel == BW'(b)) begin
            cur_byte = rd_word[b*OUT_WIDTH +: OUT_WIDTH];
         end
      end
   end

   // State register; out_valid is registered alongside the state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= FILL;
         out_valid_q <= 1'b0;
      end else begin
         state       <= next_state;
         out_valid_q <= (next_state != FILL);
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         FILL: begin
            if (row_done) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            if (out_hs && data_end) begin
`ifdef MATRIX_DRAIN_CHECKSUM_EN
               next_state = CSUM;
`else
               next_state = FILL;
`endif
            end
         end
`ifdef MATRIX_DRAIN_CHECKSUM_EN
         CSUM: begin
            if (out_hs) begin
               next_state = FILL;
            end
         end
`endif
         default: next_state = FILL;
      endcase
   end

   // Word/byte counters. They clear on the last data byte, so in CSUM the
   // only live datapath state is the checksum register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_cnt   <= '0;
         rd_idx   <= '0;
         byte_sel <= '0;
      end else begin
         case (state)
            FILL: begin
               if (accept) begin
                  wr_cnt <= wr_cnt + CW'(1);
               end
            end
            DRAIN: begin
               if (out_hs) begin
                  if (last_byte) begin
                     byte_sel <= '0;
                     if (last_word) begin
                        wr_cnt <= '0;
                        rd_idx <= '0;
                     end else begin
                        rd_idx <= rd_idx + CW'(1);
                     end
                  end else begin
                     byte_sel <= byte_sel + BW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MATRIX_DRAIN_CHECKSUM_EN
   // Running XOR of every data byte handed off; cleared while filling.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         csum <= '0;
      end else if (state == FILL) begin
         csum <= '0;
      end else if ((state == DRAIN) && out_hs) begin
         csum <= csum ^ cur_byte;
      end
   end
`endif

   // Output logic
   always_comb begin
      in_ready = (state == FILL);
      busy     = (state != FILL) || (wr_cnt != '0);
      out_data = '0;
      out_last = 1'b0;
      if (out_valid_q) begin
         case (state)
            DRAIN: begin
               out_data = cur_byte;
`ifdef MATRIX_DRAIN_CHECKSUM_EN
               out_last = 1'b0;
`else
               out_last = last_byte && last_word;
`endif
            end
`ifdef MATRIX_DRAIN_CHECKSUM_EN
            CSUM: begin
               out_data = csum;
               out_last = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_matrix_result_drain.sv
// -----------------------------------------------------------------------------
// tb_matrix_result_drain
// Self-checking bench for matrix_result_drain (default parameters).
// Word vectors with their expected byte split come from a table; expected
// bytes are queued when a word is driven and popped by the output monitor.
// Define MATRIX_DRAIN_CHECKSUM_EN for both RTL and bench to test the checksum.
// -----------------------------------------------------------------------------
module tb_matrix_result_drain;

`ifdef MATRIX_DRAIN_CHECKSUM_EN
   localparam int CSUM_EN = 1;
`else
   localparam int CSUM_EN = 0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic        out_ready = 1'b1;
   logic        busy;

   matrix_result_drain #(
      .DATA_WIDTH (16),
      .M_SIZE     (4),
      .OUT_WIDTH  (8)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] word;
      logic        last_in;
      logic [7:0]  lo;
      logic [7:0]  hi;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } exp_t;

   vec_t tbl [11];
   exp_t expq [$];

   int   total = 0;
   int   bad = 0;
   int   hs_count = 0;
   int   valid_cycles = 0;
   logic bp_mode = 1'b0;
   int   row_words = 0;
   logic [7:0] row_csum = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Output monitor / scoreboard
   logic       stall = 1'b0;
   logic [8:0] held = '0;
   logic       fill_next = 1'b0;

   always @(negedge clock) begin
      if (!reset) begin
         stall     = 1'b0;
         fill_next = 1'b0;
      end else begin
         if (!out_valid) check("idle_out_zero", {23'b0, out_last, out_data}, 32'h0);
         if (stall) check("stall_hold", {22'b0, out_valid, out_last, out_data}, {22'b0, 1'b1, held});
         if (fill_next) begin
            check("in_ready_after_row", in_ready, 1);
            fill_next = 1'b0;
         end
         if (out_valid) valid_cycles++;
         if (out_valid && out_ready) begin
            exp_t e;
            hs_count++;
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_byte: got %02h last=%b expected no byte at %0t",
                        out_data, out_last, $time);
            end else begin
               e = expq.pop_front();
               check("byte", {23'b0, out_last, out_data}, {23'b0, e.last, e.data});
            end
            if (out_last) fill_next = 1'b1;
            stall = 1'b0;
         end else if (out_valid) begin
            stall = 1'b1;
            held  = {out_last, out_data};
         end else begin
            stall = 1'b0;
         end
      end
   end

   // Downstream ready: always 1, or 0,1,0,1... starting on the first valid cycle
   always @(posedge clock) begin
      #1;
      if (bp_mode) out_ready = out_valid ? ~out_ready : 1'b1;
      else         out_ready = 1'b1;
   end

   // Queue expected bytes for table entry i, then offer it until accepted
   task automatic send_vec(input int i);
      logic ends;
      int   n;
      ends = tbl[i].last_in || (row_words == 3);
      expq.push_back('{tbl[i].lo, 1'b0});
      expq.push_back('{tbl[i].hi, ends && (CSUM_EN == 0)});
      row_csum = row_csum ^ tbl[i].lo ^ tbl[i].hi;
      if (ends) begin
         if (CSUM_EN != 0) expq.push_back('{row_csum, 1'b1});
         row_words = 0;
         row_csum  = '0;
      end else begin
         row_words++;
      end
      in_valid = 1'b1;
      in_data  = tbl[i].word;
      in_last  = tbl[i].last_in;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      if (n >= 100) check("accept_timeout", in_ready, 1);
      @(posedge clock); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (ends) begin
         check("valid_after_last_word", out_valid, 1);
         check("in_ready_in_drain", in_ready, 0);
         check("busy_in_drain", busy, 1);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((expq.size() != 0 || !in_ready) && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
      check("row_drained", expq.size(), 0);
      check("idle_in_ready", in_ready, 1);
      check("idle_busy", busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, bad=%0d", bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int base;

      tbl[0]  = '{16'h1234, 1'b0, 8'h34, 8'h12};
      tbl[1]  = '{16'hABCD, 1'b0, 8'hCD, 8'hAB};
      tbl[2]  = '{16'h0001, 1'b0, 8'h01, 8'h00};
      tbl[3]  = '{16'hFFFF, 1'b1, 8'hFF, 8'hFF};
      tbl[4]  = '{16'h00A5, 1'b0, 8'hA5, 8'h00};
      tbl[5]  = '{16'h5A00, 1'b1, 8'h00, 8'h5A};
      tbl[6]  = '{16'h0102, 1'b0, 8'h02, 8'h01};
      tbl[7]  = '{16'h8070, 1'b0, 8'h70, 8'h80};
      tbl[8]  = '{16'hC3E1, 1'b0, 8'hE1, 8'hC3};
      tbl[9]  = '{16'h00FF, 1'b0, 8'hFF, 8'h00};
      tbl[10] = '{16'h7E55, 1'b1, 8'h55, 8'h7E};

      // Reset with random inputs
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      in_last  = 1'($urandom);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 8'h00);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
      @(posedge clock); #1;
      check("rst_hold_out_valid", out_valid, 0);
      check("rst_hold_busy", busy, 0);
      in_valid = 1'b0;
      in_last  = 1'b0;
      reset    = 1'b1;
      @(posedge clock); #1;

      // Full row, out_ready held high
      for (int i = 0; i < 4; i++) send_vec(i);
      wait_idle();

      // Short row with in_valid noise during the drain
      send_vec(4);
      send_vec(5);
      n = 0;
      while (expq.size() >= 2 && n < 50) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data  = 16'($urandom);
         in_last  = 1'($urandom_range(0, 1));
         check("in_ready_low_noise", in_ready, 0);
         @(posedge clock); #1;
         n++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      wait_idle();

      // Forced drain after four words, fifth word waits for the next row
      for (int i = 6; i < 11; i++) send_vec(i);
      wait_idle();

      // Backpressure: 0,1,0,1... ready, two cycles per byte
      bp_mode      = 1'b1;
      @(posedge clock); #1;
      valid_cycles = 0;
      for (int i = 0; i < 4; i++) send_vec(i);
      wait_idle();
      check("bp_drain_cycles", valid_cycles, 2 * (8 + CSUM_EN));
      bp_mode = 1'b0;
      @(posedge clock); #1;

      // Reset in the middle of a drain
      base = hs_count;
      for (int i = 0; i < 4; i++) send_vec(i);
      n = 0;
      while (hs_count < base + 3 && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      check("mid_reset_reached", hs_count - base, 3);
      #2;
      reset = 1'b0;
      #1;
      check("mid_reset_out_valid", out_valid, 0);
      check("mid_reset_out_last", out_last, 0);
      check("mid_reset_out_data", out_data, 8'h00);
      check("mid_reset_busy", busy, 0);
      expq.delete();
      @(posedge clock); #1;
      reset = 1'b1;
      base  = hs_count;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
      end
      check("post_reset_no_bytes", hs_count - base, 0);
      check("post_reset_out_valid", out_valid, 0);

      // Recovery: a short row after the reset
      send_vec(4);
      send_vec(5);
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/matrix_result_drain.md
# matrix_result_drain

Output-side companion to the matrix accumulate unit. It captures finished 16-bit accumulator results for one matrix row, then streams them out over a narrow 8-bit valid/ready byte interface toward the chip output pins. This converts wide, bursty accumulator results into a flow-controlled byte stream the off-chip reader consumes at its own pace.

## Interface
Parameters:
- DATA_WIDTH, 16, width of one accumulated result word
- M_SIZE, 4, maximum words per row (buffer depth)
- OUT_WIDTH, 8, output byte width; DATA_WIDTH must be an integer multiple of OUT_WIDTH

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  result word present on in_data
- in_data  in  DATA_WIDTH  accumulated result word
- in_last  in  1  qualifies in_data as final word of the row
- in_ready  out  1  drain can accept a word
- out_valid  out  1  byte present on out_data
- out_data  out  OUT_WIDTH  output byte
- out_last  out  1  final byte of the row
- out_ready  in  1  downstream accepts the byte
- busy  out  1  high whenever state is not FILL or word count is nonzero

## Operation
- States: FILL, DRAIN (plus CSUM with the macro). Reset state is FILL.
- FILL: in_ready=1. Word accepted on in_valid&&in_ready and written to buffer[wr_cnt]; wr_cnt increments.
- FILL→DRAIN when an accepted word has in_last=1, or is the M_SIZE-th word (forced; in_last not required).
- DRAIN: in_ready=0, and in_valid is ignored. out_valid=1. Words are emitted in capture order. Each word is emitted least-significant byte first, DATA_WIDTH/OUT_WIDTH bytes per word. The byte advances only on out_valid&&out_ready.
- out_last=1 only while the final byte of the final captured word is presented.
- DRAIN→FILL on handshake of the out_last byte. Counters clear and buffer contents are don't-care.
- out_data=0 and out_last=0 whenever out_valid=0.
- Unused buffer entries are never emitted. A row of N words yields exactly N·DATA_WIDTH/OUT_WIDTH bytes.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0. The buffer is not reset.
- Reset is asynchronous. Assertion mid-row immediately drops out_valid and out_last, and the row is discarded.
- Last word captured at edge N. out_valid is high after edge N, so the first byte can transfer at edge N+1.
- Throughput: one byte per cycle while out_ready=1.
- Final byte handshake at edge K. in_ready is high after edge K, so the next row's first capture can occur at edge K+1. No overlap between FILL and DRAIN.
- Stall (out_ready=0): out_data and out_last hold stable. out_valid is never withdrawn without a handshake.
- State, counters and out_valid are registered. out_data is a mux of the buffer selected by registered indices.

## Configuration
- MATRIX_DRAIN_CHECKSUM_EN defined: after the last data byte, state CSUM emits one extra byte. That byte is the XOR of all data bytes of the row. out_last moves to the checksum byte, and CSUM→FILL on its handshake.
- Undefined: no CSUM state and no checksum logic. out_last sits on the last data byte.

## Structure
- Shared package matrix_pkg holds:
  - DATA_WIDTH, M_SIZE and OUT_WIDTH constants
  - drain state enum typedef
  - bytes-per-word constant
  - counter width derived via $clog2(M_SIZE+1)
- One sub-module, matrix_drain_buffer: an M_SIZE×DATA_WIDTH register array with write enable, write index and combinational read index. The FSM, counters and byte select stay in matrix_result_drain.

## Test plan
- Reset: assert reset with random inputs → in_ready=1, out_valid=0, out_data=0x00, busy=0.
- Full row, M_SIZE=4, out_ready=1: 0x1234, 0xABCD, 0x0001, 0xFFFF with in_last on the 4th → bytes 34,12,CD,AB,01,00,FF,FF. out_last is on the 8th byte only. in_ready=1 the cycle after.
- Short row: 0x00A5, then 0x5A00 with in_last → bytes A5,00,00,5A with out_last on the 4th. in_valid pulses during DRAIN are ignored, and in_ready=0 throughout.
- Forced drain: four words without in_last → DRAIN entered and 8 bytes emitted. A 5th word offered waits until FILL and starts the next row.
- Backpressure: full-row stimulus with out_ready alternating 1,0 → each byte held stable through the stall, sequence identical, 16 cycles total to drain.
- Mid-drain reset, then checksum: reset after 3 bytes → out_valid=0 immediately and no residual bytes after release. With MATRIX_DRAIN_CHECKSUM_EN, the full-row stimulus → 9th byte 0x41 with out_last.
